// File: rtl/mipsdefs_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM states, mux encodings.
// The MIPSCTRL_BNE_EN macro adds the bne branch strobe to the control word.
package mipsdefs;

  localparam int unsigned ST_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_HALT     = 4'd12,
    S_BRANCHNE = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    SRCB_RT    = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic     pcwrite;
    logic     pcwritecond;
`ifdef MIPSCTRL_BNE_EN
    logic     pcwritecondne;
`endif
    logic     iord;
    logic     memread;
    logic     memwrite;
    logic     irwrite;
    logic     memtoreg;
    logic     regdst;
    logic     regwrite;
    logic     alusrca;
    alusrcb_t alusrcb;
    aluop_t   aluop;
    pcsrc_t   pcsrc;
    logic     fin;
  } ctrl_t;

endpackage

// File: rtl/mipsctrl_outdec.sv
// State -> control-word decoder for the multi-cycle MIPS controller (combinational).
// Optional macro MIPSCTRL_BNE_EN decodes the BRANCHNE state.
module mipsctrl_outdec
  import mipsdefs::*;
(
  input  state_t state,
  input  logic   memready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        // IR and PC load only on the cycle the fetch read completes
        ctrl.irwrite = memready;
        ctrl.pcwrite = memready;
      end
      S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsrc       = PC_ALUOUT;
      end
`ifdef MIPSCTRL_BNE_EN
      S_BRANCHNE: begin
        ctrl.alusrca       = 1'b1;
        ctrl.aluop         = ALU_SUB;
        ctrl.pcwritecondne = 1'b1;
        ctrl.pcsrc         = PC_ALUOUT;
      end
`endif
      S_JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PC_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_HALT:   ctrl.fin      = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mipsmulticlk_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath; outputs decoded from the state register.
// Optional macro MIPSCTRL_BNE_EN adds the pcwritecondne port and bne decoding.
module mipsmulticlk_ctrl
  import mipsdefs::*;
#(
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       pcclr,
  input  logic [5:0] opcode,
  input  logic       memready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
`ifdef MIPSCTRL_BNE_EN
  output logic       pcwritecondne,
`endif
  output logic       fin
);

  logic [STATE_W-1:0] state_q;
  state_t             state;
  ctrl_t              ctrl;

  assign state = state_t'(state_q);

  function automatic state_t dispatch(input logic [5:0] op);
    state_t nxt;
    nxt = S_FETCH;
    if (op == HALT_OP) begin
      nxt = S_HALT;
    end else begin
      case (op)
        OP_LW, OP_SW: nxt = S_MEMADR;
        OP_RTYPE:     nxt = S_EXEC;
        OP_BEQ:       nxt = S_BRANCH;
`ifdef MIPSCTRL_BNE_EN
        OP_BNE:       nxt = S_BRANCHNE;
`endif
        OP_J:         nxt = S_JUMP;
        OP_ADDI:      nxt = S_ADDIEX;
        default:      nxt = S_FETCH;
      endcase
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge pcclr) begin
    if (!pcclr) begin
      state_q <= STATE_W'(S_FETCH);
    end else begin
      case (state)
        S_FETCH:  if (memready) state_q <= STATE_W'(S_DECODE);
        S_DECODE: state_q <= STATE_W'(dispatch(opcode));
        // IR still holds the opcode here, so lw/sw split one state late
        S_MEMADR: state_q <= (opcode == OP_SW) ? STATE_W'(S_MEMWR) : STATE_W'(S_MEMRD);
        S_MEMRD:  if (memready) state_q <= STATE_W'(S_MEMWB);
        S_MEMWR:  if (memready) state_q <= STATE_W'(S_FETCH);
        S_EXEC:   state_q <= STATE_W'(S_ALUWB);
        S_ADDIEX: state_q <= STATE_W'(S_ADDIWB);
        S_HALT:   state_q <= STATE_W'(S_HALT);
        default:  state_q <= STATE_W'(S_FETCH);
      endcase
    end
  end

  mipsctrl_outdec u_outdec (
    .state    (state),
    .memready (memready),
    .ctrl     (ctrl)
  );

  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop       = ctrl.aluop;
  assign pcsrc       = ctrl.pcsrc;
`ifdef MIPSCTRL_BNE_EN
  assign pcwritecondne = ctrl.pcwritecondne;
`endif
  assign fin         = ctrl.fin;

endmodule

// File: tb/tb_mipsmulticlk_ctrl.sv
// Self-checking bench for mipsmulticlk_ctrl: per-instruction control-word sequences vs. DUT outputs.
// Works with or without MIPSCTRL_BNE_EN defined.
module tb_mipsmulticlk_ctrl;

  localparam logic [5:0] HALT = 6'b111111;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       pcclr, memready;
  logic [5:0] opcode;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, fin, bne_o;
  logic [1:0] alusrcb, aluop, pcsrc;

  typedef struct packed {
    logic pcwrite, pcwritecond, pcwritecondne, iord, memread, memwrite, irwrite;
    logic memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic fin;
  } cw_t;

  cw_t act;
  cw_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  mipsmulticlk_ctrl #(.HALT_OP(HALT), .STATE_W(4)) dut (
    .clk(clk), .pcclr(pcclr), .opcode(opcode), .memready(memready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc),
`ifdef MIPSCTRL_BNE_EN
    .pcwritecondne(bne_o),
`endif
    .fin(fin)
  );

`ifndef MIPSCTRL_BNE_EN
  assign bne_o = 1'b0;
`endif

  assign act = {pcwrite, pcwritecond, bne_o, iord, memread, memwrite, irwrite,
                memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc, fin};

  always #5 clk = ~clk;

  // Control word the datapath must see in each phase of an instruction.
  function automatic cw_t word(input string st, input logic ready);
    cw_t w = '0;
    case (st)
      "fetch":    begin w.memread = 1'b1; w.alusrcb = 2'b01; w.irwrite = ready; w.pcwrite = ready; end
      "decode":   w.alusrcb = 2'b11;
      "memadr":   begin w.alusrca = 1'b1; w.alusrcb = 2'b10; end
      "memrd":    begin w.memread = 1'b1; w.iord = 1'b1; end
      "memwb":    begin w.regwrite = 1'b1; w.memtoreg = 1'b1; end
      "memwr":    begin w.memwrite = 1'b1; w.iord = 1'b1; end
      "exec":     begin w.alusrca = 1'b1; w.aluop = 2'b10; end
      "aluwb":    begin w.regwrite = 1'b1; w.regdst = 1'b1; end
      "branch":   begin w.alusrca = 1'b1; w.aluop = 2'b01; w.pcwritecond = 1'b1; w.pcsrc = 2'b01; end
      "branchne": begin w.alusrca = 1'b1; w.aluop = 2'b01; w.pcwritecondne = 1'b1; w.pcsrc = 2'b01; end
      "jump":     begin w.pcwrite = 1'b1; w.pcsrc = 2'b10; end
      "addiex":   begin w.alusrca = 1'b1; w.alusrcb = 2'b10; end
      "addiwb":   w.regwrite = 1'b1;
      "halt":     w.fin = 1'b1;
      default:    ;
    endcase
    return w;
  endfunction

  always @(negedge clk) begin
    cw_t e;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_word cycle %0d op=%b: actual=%h required=%h", cyc, opcode, act, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, a, e);
    end
  endtask

  // Called at posedge+1: drive this cycle's inputs, queue its expected word, advance one edge.
  task automatic step(input logic mr, input string st);
    memready = mr;
    exp_q.push_back(word(st, mr));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    pcclr = 1'b0;
    memready = 1'b0;
    #1;
    check("reset_fin", fin, 0);
    check("reset_memread", memread, 1);
    check("reset_memwrite", memwrite, 0);
    @(posedge clk);
    #1;
    pcclr = 1'b1;
  endtask

  // fw/mw < 0 pick a random number of wait cycles in fetch / memory state
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int nf = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    int nm = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
    opcode = op;
    repeat (nf) step(1'b0, "fetch");
    step(1'b1, "fetch");
    step(rb(), "decode");
    if (op == HALT) begin
      repeat (12) step(rb(), "halt");
      do_reset();
    end else begin
      case (op)
        LW: begin
          step(rb(), "memadr");
          repeat (nm) step(1'b0, "memrd");
          step(1'b1, "memrd");
          step(rb(), "memwb");
        end
        SW: begin
          step(rb(), "memadr");
          repeat (nm) step(1'b0, "memwr");
          step(1'b1, "memwr");
        end
        RT:   begin step(rb(), "exec"); step(rb(), "aluwb"); end
        BEQ:  step(rb(), "branch");
`ifdef MIPSCTRL_BNE_EN
        BNE:  step(rb(), "branchne");
`endif
        JMP:  step(rb(), "jump");
        ADDI: begin step(rb(), "addiex"); step(rb(), "addiwb"); end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [5:0] ops [0:8];
    ops = '{LW, SW, RT, BEQ, BNE, JMP, ADDI, 6'b111000, 6'b000000};
    pcclr = 1'b0;
    memready = 1'b0;
    opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_memread", memread, 1);
    check("rst_alusrcb", alusrcb, 2'b01);
    check("rst_irwrite", irwrite, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_fin", fin, 0);
    pcclr = 1'b1;

    run_instr(LW, 0, 0);
    run_instr(SW, 0, 3);
    run_instr(RT, 1, 0);
    run_instr(BEQ, 0, 0);
    run_instr(6'b111000, 0, 0);
    run_instr(BNE, 0, 0);
    run_instr(JMP, 2, 0);
    run_instr(ADDI, 0, 0);
    run_instr(LW, 1, 2);

    for (int i = 0; i < 150; i++) begin
      ops[8] = 6'($urandom);
      run_instr(ops[$urandom_range(0, 8)], -1, -1);
    end

    // Abort a stalled store: memwrite must drop the instant pcclr falls.
    opcode = SW;
    step(1'b1, "fetch");
    step(1'b1, "decode");
    step(1'b1, "memadr");
    step(1'b0, "memwr");
    step(1'b0, "memwr");
    memready = 1'b0;
    #1;
    check("abort_pre_memwrite", memwrite, 1);
    pcclr = 1'b0;
    #1;
    check("abort_memwrite", memwrite, 0);
    check("abort_iord", iord, 0);
    check("abort_memread", memread, 1);
    check("abort_fin", fin, 0);
    @(posedge clk);
    #1;
    pcclr = 1'b1;
    run_instr(ADDI, 0, 0);

    // HALT: fin rises on the second edge after its fetch begins and sticks.
    opcode = HALT;
    step(1'b1, "fetch");
    check("halt_fin_edge1", fin, 0);
    step(1'b0, "decode");
    check("halt_fin_edge2", fin, 1);
    repeat (11) step(rb(), "halt");
    check("halt_fin_sticky", fin, 1);
    check("halt_regwrite", regwrite, 0);
    do_reset();
    run_instr(RT, 0, 0);

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
